// File: rtl/vga_pkg.sv
// Shared definitions for the VGA line-buffer path: line geometry, pixel width
// and the one-hot state encoding of the save controller.
package vga_pkg;

    localparam int XSIZE_DEF = 512;
    localparam int PIX_W     = 16;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FILL  = 4'b0010,
        FULL  = 4'b0100,
        DRAIN = 4'b1000
    } state_t;

endpackage

// File: rtl/vga_savectl.sv
// Line-buffer sequencing: fills exactly XSIZE pixels per requested line, then
// reads them out for XSIZE cycles once the next active-video region starts.
module vga_savectl
    import vga_pkg::*;
#(
    parameter int XSIZE = XSIZE_DEF,
    parameter int CW    = 10
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             iLineReq,
    input  logic             iActive,
    input  logic             iSrcValid,
    input  logic [PIX_W-1:0] iSrcData,
    output logic             oSrcReady,
    output logic             oWrEn,
    output logic [PIX_W-1:0] oWrData,
    output logic             oRdEn,
    output logic             oBusy,
    output logic             oLineDone,
    output logic             oUnderrun,
    output logic             oDropped
);

    localparam logic [CW-1:0] LAST = CW'(XSIZE - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    wcnt, rcnt;
    logic             pend, active_q;
    logic             accept, fill_entry;
    logic             wr_en, underrun, dropped;
    logic [PIX_W-1:0] wr_data;

    assign accept     = iSrcValid && (state == FILL);
    assign fill_entry = (state_nx == FILL) && (state != FILL);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (iLineReq) state_nx = FILL;
            FILL:    if (accept && wcnt == LAST) state_nx = FULL;
            FULL:    if (iActive) state_nx = DRAIN;
            // A request arriving on the final read cycle still counts as pending
            DRAIN:   if (rcnt == LAST) state_nx = (pend || iLineReq) ? FILL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= IDLE;
            wcnt     <= '0;
            rcnt     <= '0;
            pend     <= 1'b0;
            active_q <= 1'b0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            underrun <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= state_nx;
            active_q <= iActive;
            wr_en    <= accept;
            if (accept) wr_data <= iSrcData;
            underrun <= (state == FILL) && iActive && !active_q;
            dropped  <= iLineReq && ((state == FILL) || (state == FULL));

            if (fill_entry)  wcnt <= '0;
            else if (accept) wcnt <= wcnt + 1'b1;

            if ((state == FULL) && (state_nx == DRAIN)) rcnt <= '0;
            else if (state == DRAIN)                    rcnt <= rcnt + 1'b1;

            if (fill_entry)                         pend <= 1'b0;
            else if ((state == DRAIN) && iLineReq)  pend <= 1'b1;
        end
    end

    // Ready/read/busy come straight off state flops; no input-to-output path
    assign oSrcReady = (state == FILL);
    assign oRdEn     = (state == DRAIN);
    assign oBusy     = (state != IDLE);
    assign oLineDone = (state == DRAIN) && (rcnt == LAST);
    assign oWrEn     = wr_en;
    assign oWrData   = wr_data;
    assign oUnderrun = underrun;
    assign oDropped  = dropped;

endmodule

// File: tb/tb_vga_savectl.sv
// Bench for vga_savectl: a line-level reference model plus a line-buffer model
// driven by the DUT enables, checked every cycle, with scenario-level literals.
module tb_vga_savectl;

    localparam int XSIZE = 512;
    localparam int CW    = 10;
    localparam int S_IDLE = 0, S_FILL = 1, S_FULL = 2, S_DRAIN = 3;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        iLineReq = 1'b0;
    logic        iActive = 1'b0;
    logic        iSrcValid = 1'b0;
    logic [15:0] iSrcData = '0;
    logic        oSrcReady, oWrEn, oRdEn, oBusy, oLineDone, oUnderrun, oDropped;
    logic [15:0] oWrData;

    vga_savectl #(.XSIZE(XSIZE), .CW(CW)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iLineReq(iLineReq), .iActive(iActive),
        .iSrcValid(iSrcValid), .iSrcData(iSrcData), .oSrcReady(oSrcReady),
        .oWrEn(oWrEn), .oWrData(oWrData), .oRdEn(oRdEn), .oBusy(oBusy),
        .oLineDone(oLineDone), .oUnderrun(oUnderrun), .oDropped(oDropped)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: phase of the line, pixels taken, reads done, pending request
    int          m_st = S_IDLE, m_w = 0, m_r = 0, cyc = 0;
    bit          m_pend = 0, m_actq = 0, started = 0;
    bit          e_wren = 0, e_under = 0, e_drop = 0;
    logic [15:0] e_wdata = '0;
    logic [15:0] m_line [XSIZE];
    logic [15:0] m_show [XSIZE];

    // Line buffer: wrapping write pointer, read pointer rewinds while read is low
    logic [15:0] bmem [XSIZE];
    int          bwp = 0, brp = 0, bidx = 0, rb0_cyc = 0;
    logic [15:0] bq = '0;
    bit          bval = 0;

    int n_wr = 0, n_rd = 0, n_done = 0, n_under = 0, n_drop = 0, n_rb = 0;
    int s_wr, s_rd, s_done, s_under, s_drop, s_rb;
    int vprob = 100, vmode = 0, pmul = 1, pbase = 0, act_cyc = 0;
    bit src_on = 0;

    function automatic logic [15:0] pat(input int i);
        return 16'(i * pmul + pbase);
    endfunction

    always @(posedge CLOCK) begin
        bit acc, req;
        cyc++;
        started = 1;
        if (RESET) begin
            bwp = 0; brp = 0; bval = 0;
        end else begin
            if (oWrEn) begin bmem[bwp] = oWrData; bwp = (bwp + 1) % XSIZE; end
            if (oRdEn) begin
                bq = bmem[brp]; bidx = brp; bval = 1;
                if (brp == 0) rb0_cyc = cyc;
                brp = (brp + 1) % XSIZE;
            end else begin
                bval = 0; brp = 0;
            end
        end

        if (RESET) begin
            m_st = S_IDLE; m_w = 0; m_r = 0; m_pend = 0; m_actq = 0;
            e_wren = 0; e_wdata = '0; e_under = 0; e_drop = 0;
        end else begin
            acc     = (m_st == S_FILL) && iSrcValid;
            req     = iLineReq;
            e_wren  = acc;
            if (acc) begin e_wdata = iSrcData; m_line[m_w] = iSrcData; end
            e_drop  = req && (m_st == S_FILL || m_st == S_FULL);
            e_under = (m_st == S_FILL) && iActive && !m_actq;
            m_actq  = iActive;
            case (m_st)
                S_IDLE: if (req) begin m_st = S_FILL; m_w = 0; end
                S_FILL: if (acc) begin m_w++; if (m_w == XSIZE) m_st = S_FULL; end
                S_FULL: if (iActive) begin m_st = S_DRAIN; m_r = 0; m_show = m_line; end
                default: begin
                    if (req) m_pend = 1;
                    if (m_r == XSIZE - 1) begin
                        if (m_pend) begin m_st = S_FILL; m_w = 0; m_pend = 0; end
                        else m_st = S_IDLE;
                    end else m_r++;
                end
            endcase
        end
    end

    always @(negedge CLOCK) begin
        if (started) begin
            chk("src_ready", oSrcReady, m_st == S_FILL);
            chk("wr_en", oWrEn, e_wren);
            chk("wr_data", oWrData, e_wdata);
            chk("rd_en", oRdEn, m_st == S_DRAIN);
            chk("busy", oBusy, m_st != S_IDLE);
            chk("line_done", oLineDone, (m_st == S_DRAIN) && (m_r == XSIZE - 1));
            chk("underrun", oUnderrun, e_under);
            chk("dropped", oDropped, e_drop);
            if (bval) chk("readback", bq, m_show[bidx]);
            n_wr += oWrEn; n_rd += oRdEn; n_done += oLineDone;
            n_under += oUnderrun; n_drop += oDropped; n_rb += bval;
        end
    end

    // Source: valid pattern independent of ready; data indexes the next pixel
    initial forever begin
        @(posedge CLOCK); #1;
        iSrcValid = src_on && (vmode == 1 ? (cyc % 3 == 0) : ($urandom_range(99) < vprob));
        iSrcData  = (m_st == S_FILL) ? pat(m_w) : 16'($urandom_range(65535));
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge CLOCK); #1; end
    endtask

    task automatic pulse_req();
        iLineReq = 1'b1; step(); iLineReq = 1'b0;
    endtask

    task automatic wait_st(input int st, input string nm);
        int k = 0;
        while (m_st != st && k < 6000) begin step(); k++; end
        chk(nm, m_st, st);
    endtask

    task automatic wait_w(input int n, input string nm);
        int k = 0;
        while (!(m_st == S_FILL && m_w == n) && k < 6000) begin step(); k++; end
        chk(nm, m_w, n);
    endtask

    task automatic wait_r(input int n, input string nm);
        int k = 0;
        while (!(m_st == S_DRAIN && m_r == n) && k < 6000) begin step(); k++; end
        chk(nm, m_r, n);
    endtask

    task automatic run_drain();
        act_cyc = cyc; iActive = 1'b1;
        step(XSIZE + 4);
        iActive = 1'b0;
        step(4);
    endtask

    task automatic snap();
        s_wr = n_wr; s_rd = n_rd; s_done = n_done;
        s_under = n_under; s_drop = n_drop; s_rb = n_rb;
    endtask

    task automatic expect_delta(input string nm, input int wr, input int done,
                                input int under, input int drop);
        chk({nm, "_writes"}, n_wr - s_wr, wr);
        chk({nm, "_reads"}, n_rd - s_rd, wr);
        chk({nm, "_readback_words"}, n_rb - s_rb, wr);
        chk({nm, "_line_done"}, n_done - s_done, done);
        chk({nm, "_underrun"}, n_under - s_under, under);
        chk({nm, "_dropped"}, n_drop - s_drop, drop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        src_on = 1;
        step(3);
        chk("rst_busy", oBusy, 0);
        chk("rst_src_ready", oSrcReady, 0);
        chk("rst_wr_en", oWrEn, 0);
        chk("rst_wr_data", oWrData, 0);
        chk("rst_rd_en", oRdEn, 0);
        chk("rst_line_done", oLineDone, 0);
        RESET = 1'b0;
        step(2);

        // Nominal line, source valid every cycle
        snap(); pulse_req();
        wait_st(S_FULL, "nom_full");
        step(4); run_drain();
        expect_delta("nom", XSIZE, 1, 0, 0);
        chk("nom_rb_latency", rb0_cyc - act_cyc, 2);
        chk("nom_first_pix", m_show[0], 0);
        chk("nom_last_pix", m_show[XSIZE-1], 511);

        // Bursty 1-in-3 source
        vmode = 1; pmul = 3; pbase = 100;
        snap(); pulse_req();
        wait_st(S_FULL, "burst_full");
        step(2); run_drain();
        expect_delta("burst", XSIZE, 1, 0, 0);
        chk("burst_first_pix", m_show[0], 100);
        chk("burst_last_pix", m_show[XSIZE-1], 1633);

        // Underrun: active rises mid-fill, that line is skipped
        vmode = 0; vprob = 50; pmul = 7; pbase = 5;
        snap(); pulse_req();
        wait_w(300, "under_300");
        iActive = 1'b1; step(20); iActive = 1'b0;
        wait_st(S_FULL, "under_full");
        step(3); run_drain();
        expect_delta("under", XSIZE, 1, 1, 0);

        // Request during drain is kept; request during fill is dropped
        vprob = 100; pmul = 1; pbase = 1000;
        snap(); pulse_req();
        wait_st(S_FULL, "pend_full");
        step(2); iActive = 1'b1;
        wait_r(100, "pend_r100");
        pulse_req();
        wait_st(S_FILL, "pend_refill");
        iActive = 1'b0;
        chk("pend_no_drop", n_drop - s_drop, 0);
        chk("pend_done", n_done - s_done, 1);
        pbase = 5000; vprob = 70;
        wait_w(50, "pend_fill50");
        pulse_req(); step(2);
        chk("fill_req_dropped", n_drop - s_drop, 1);
        chk("fill_req_stays", oSrcReady, 1);
        wait_st(S_FULL, "pend2_full");
        step(1); run_drain();
        expect_delta("pend", 2 * XSIZE, 2, 0, 1);

        // Reset in the middle of a fill
        vprob = 100; pbase = 2000;
        pulse_req();
        wait_w(200, "rst_fill200");
        RESET = 1'b1; step(); RESET = 1'b0;
        chk("midrst_busy", oBusy, 0);
        chk("midrst_src_ready", oSrcReady, 0);
        chk("midrst_wr_en", oWrEn, 0);
        chk("midrst_wr_data", oWrData, 0);
        chk("midrst_rd_en", oRdEn, 0);
        chk("midrst_underrun", oUnderrun, 0);
        chk("midrst_dropped", oDropped, 0);
        pbase = 3000;
        step(2); snap(); pulse_req();
        wait_st(S_FULL, "postrst_full");
        step(2); run_drain();
        expect_delta("postrst", XSIZE, 1, 0, 0);
        chk("postrst_first_pix", m_show[0], 3000);

        // Back-to-back lines with distinct patterns
        snap();
        for (int li = 0; li < 4; li++) begin
            pmul = 2 * li + 1; pbase = li * 4096 + 17;
            vprob = int'($urandom_range(30, 100));
            pulse_req();
            wait_st(S_FULL, "b2b_full");
            step(int'($urandom_range(0, 5)));
            run_drain();
        end
        expect_delta("b2b", 4 * XSIZE, 4, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
